// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter sharing one single-port word memory between fetch and data.
// Tracks in-flight reads with a tag pipeline matching the memory read latency.
module mem_port_arbiter #(
  parameter int ADDR_W   = 15,
  parameter int DATA_W   = 16,
  parameter int LATENCY  = 1,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  input  logic              f_flush,
  output logic              f_gnt,
  output logic              f_rvalid,
  output logic [DATA_W-1:0] f_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              starve
);

  localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

  logic [3:0]         wait_cnt;
  logic               starve_now;
  logic [LATENCY-1:0] tag_vld_p;
  logic [LATENCY-1:0] tag_src_p;
  logic               last_vld;
  logic               last_src;

  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    return (v == WAIT_MAX) ? v : v + 4'd1;
  endfunction

  assign starve_now = (wait_cnt == WAIT_MAX);
  assign starve     = ~rst & starve_now;

  // Request stage: same-cycle grant and memory drive
  always_comb begin
    f_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      if (f_req && (!d_req || starve_now))
        f_gnt = 1'b1;
      else if (d_req)
        d_gnt = 1'b1;
    end
  end

  always_comb begin
    m_en    = f_gnt | d_gnt;
    m_we    = d_gnt & d_we;
    m_addr  = '0;
    m_wdata = '0;
    if (d_gnt)
      m_addr = d_addr;
    else if (f_gnt)
      m_addr = f_addr;
    if (m_we)
      m_wdata = d_wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wait_cnt <= 4'd0;
    else if (f_req && !f_gnt)
      wait_cnt <= sat_inc(wait_cnt);
    else
      wait_cnt <= 4'd0;
  end

  // Tag stages p0..p(LATENCY-1); a flush kills older fetch tags, never the one entering p0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_vld_p <= '0;
      tag_src_p <= '0;
    end else begin
      tag_vld_p[0] <= m_en & ~m_we;
      tag_src_p[0] <= d_gnt;
      for (int i = 1; i < LATENCY; i++) begin
        tag_vld_p[i] <= tag_vld_p[i-1] & ~(f_flush & ~tag_src_p[i-1]);
        tag_src_p[i] <= tag_src_p[i-1];
      end
    end
  end

  // Response stage: last tag lines up with m_rdata
  assign last_vld = tag_vld_p[LATENCY-1];
  assign last_src = tag_src_p[LATENCY-1];

  always_comb begin
    d_rvalid = ~rst & last_vld & last_src;
    f_rvalid = ~rst & last_vld & ~last_src & ~f_flush;
    d_rdata  = d_rvalid ? m_rdata : '0;
    f_rdata  = f_rvalid ? m_rdata : '0;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (latency 1 and 2) share stimulus,
// each with its own memory model; directed scenarios then a randomized run.
module tb_mem_port_arbiter;
  localparam int AW = 15;
  localparam int DW = 16;
  localparam int MW = 3;

  typedef struct {
    int          due;
    bit          src;
    logic [15:0] data;
  } resp_t;

  logic clk = 1'b0;
  logic rst, mem_load;
  logic f_req, f_flush, d_req, d_we;
  logic [AW-1:0] f_addr, d_addr;
  logic [DW-1:0] d_wdata;

  logic f_gnt1, d_gnt1, f_rvalid1, d_rvalid1, m_en1, m_we1, starve1;
  logic [DW-1:0] f_rdata1, d_rdata1, m_wdata1;
  logic [AW-1:0] m_addr1;
  logic f_gnt2, d_gnt2, f_rvalid2, d_rvalid2, m_en2, m_we2, starve2;
  logic [DW-1:0] f_rdata2, d_rdata2, m_wdata2;
  logic [AW-1:0] m_addr2;

  logic [DW-1:0] mem1 [64];
  logic [DW-1:0] mem2 [64];
  logic [DW-1:0] rd1, rd2a, rd2b;
  logic [DW-1:0] ref_mem [64];

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(1), .MAX_WAIT(MW)) u_lat1 (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_gnt(f_gnt1), .f_rvalid(f_rvalid1), .f_rdata(f_rdata1),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt1), .d_rvalid(d_rvalid1), .d_rdata(d_rdata1),
    .m_en(m_en1), .m_we(m_we1), .m_addr(m_addr1), .m_wdata(m_wdata1),
    .m_rdata(rd1), .starve(starve1)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2), .MAX_WAIT(MW)) u_lat2 (
    .clk(clk), .rst(rst), .f_req(f_req), .f_addr(f_addr), .f_flush(f_flush),
    .f_gnt(f_gnt2), .f_rvalid(f_rvalid2), .f_rdata(f_rdata2),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt2), .d_rvalid(d_rvalid2), .d_rdata(d_rdata2),
    .m_en(m_en2), .m_we(m_we2), .m_addr(m_addr2), .m_wdata(m_wdata2),
    .m_rdata(rd2b), .starve(starve2)
  );

  function automatic logic [15:0] init_val(input int i);
    return 16'(i * 37 + 32'h5A00);
  endfunction

  // Single-port memories: 1-cycle and 2-cycle read latency
  always_ff @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 64; i++) begin
        mem1[i] <= init_val(i);
        mem2[i] <= init_val(i);
      end
    end else begin
      if (m_en1 && m_we1) mem1[m_addr1[5:0]] <= m_wdata1;
      if (m_en2 && m_we2) mem2[m_addr2[5:0]] <= m_wdata2;
    end
    rd1  <= mem1[m_addr1[5:0]];
    rd2a <= mem2[m_addr2[5:0]];
    rd2b <= rd2a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    f_req = 1'b0; f_addr = '0; f_flush = 1'b0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
  endtask

  task automatic test_reset();
    idle(); f_req = 1'b1; f_addr = 15'd3; tick();
    f_req = 1'b0; d_req = 1'b1; d_addr = 15'd4; tick();
    f_req = 1'b1; f_addr = 15'd6; d_we = 1'b1; d_addr = 15'd8; d_wdata = 16'h1234;
    #2;
    n_checks++;
    if ({f_rvalid2, f_rdata2} !== {1'b1, init_val(3)})
      $display("FAIL reset_pre_fetch2 got %b/%h want 1/%h", f_rvalid2, f_rdata2, init_val(3));
    else n_pass++;
    n_checks++;
    if ({d_rvalid1, d_rdata1} !== {1'b1, init_val(4)})
      $display("FAIL reset_pre_load1 got %b/%h want 1/%h", d_rvalid1, d_rdata1, init_val(4));
    else n_pass++;
    rst = 1'b1;
    #1;
    n_checks++;
    if ({f_gnt1, d_gnt1, starve1, m_en1, m_we1, f_rvalid1, d_rvalid1, m_addr1, m_wdata1, f_rdata1, d_rdata1} !== '0)
      $display("FAIL reset_outs1 got gnt=%b%b en=%b we=%b rv=%b%b addr=%h wd=%h want all 0",
               f_gnt1, d_gnt1, m_en1, m_we1, f_rvalid1, d_rvalid1, m_addr1, m_wdata1);
    else n_pass++;
    n_checks++;
    if ({f_gnt2, d_gnt2, starve2, m_en2, m_we2, f_rvalid2, d_rvalid2, m_addr2, m_wdata2, f_rdata2, d_rdata2} !== '0)
      $display("FAIL reset_outs2 got gnt=%b%b en=%b we=%b rv=%b%b addr=%h wd=%h want all 0",
               f_gnt2, d_gnt2, m_en2, m_we2, f_rvalid2, d_rvalid2, m_addr2, m_wdata2);
    else n_pass++;
    idle();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #3;
      n_checks++;
      if ({f_rvalid1, d_rvalid1, f_rvalid2, d_rvalid2} !== 4'b0)
        $display("FAIL reset_no_rvalid k=%0d got %b want 0000", k, {f_rvalid1, d_rvalid1, f_rvalid2, d_rvalid2});
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_fetch_only();
    logic [16:0] exp;
    for (int k = 0; k < 5; k++) begin
      idle();
      f_req  = (k < 3);
      f_addr = (k < 3) ? 15'(k) : 15'd0;
      #3;
      if (k < 3) begin
        n_checks++;
        if ({f_gnt1, d_gnt1, m_addr1} !== {1'b1, 1'b0, 15'(k)})
          $display("FAIL fetch_gnt k=%0d got gnt=%b addr=%0d want 1/%0d", k, f_gnt1, m_addr1, k);
        else n_pass++;
      end
      exp = (k >= 1 && k <= 3) ? {1'b1, init_val(k - 1)} : 17'd0;
      n_checks++;
      if ({f_rvalid1, f_rdata1} !== exp)
        $display("FAIL fetch_resp1 k=%0d got %b/%h want %b/%h", k, f_rvalid1, f_rdata1, exp[16], exp[15:0]);
      else n_pass++;
      exp = (k >= 2) ? {1'b1, init_val(k - 2)} : 17'd0;
      n_checks++;
      if ({f_rvalid2, f_rdata2} !== exp)
        $display("FAIL fetch_resp2 k=%0d got %b/%h want %b/%h", k, f_rvalid2, f_rdata2, exp[16], exp[15:0]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_contention();
    bit is_f, prev_f;
    logic [14:0] exp_addr;
    logic [33:0] exp_resp;
    idle();
    f_addr = 15'd20; d_addr = 15'd30;
    for (int k = 0; k < 9; k++) begin
      f_req = (k < 8); d_req = (k < 8);
      #3;
      is_f   = (k == 3 || k == 7);
      prev_f = (k == 4 || k == 8);
      exp_addr = is_f ? 15'd20 : ((k < 8) ? 15'd30 : 15'd0);
      n_checks++;
      if ({f_gnt1, d_gnt1, starve1} !== {is_f, (k < 8) && !is_f, is_f})
        $display("FAIL contention_gnt k=%0d got f=%b d=%b st=%b want f=%b st=%b", k, f_gnt1, d_gnt1, starve1, is_f, is_f);
      else n_pass++;
      n_checks++;
      if (m_addr1 !== exp_addr)
        $display("FAIL contention_addr k=%0d got %0d want %0d", k, m_addr1, exp_addr);
      else n_pass++;
      if (k >= 1) begin
        exp_resp = prev_f ? {1'b1, init_val(20), 1'b0, 16'h0} : {1'b0, 16'h0, 1'b1, init_val(30)};
        n_checks++;
        if ({f_rvalid1, f_rdata1, d_rvalid1, d_rdata1} !== exp_resp)
          $display("FAIL contention_route k=%0d got f=%b/%h d=%b/%h want %h", k, f_rvalid1, f_rdata1, d_rvalid1, d_rdata1, exp_resp);
        else n_pass++;
      end
      tick();
    end
    idle();
  endtask

  task automatic test_store_load();
    idle(); d_req = 1'b1; d_we = 1'b1; d_addr = 15'd5; d_wdata = 16'hBEEF;
    #3;
    n_checks++;
    if ({m_en1, m_we1, d_gnt1, f_gnt1, m_addr1, m_wdata1} !== {4'b1110, 15'd5, 16'hBEEF})
      $display("FAIL store_drive got en=%b we=%b gnt=%b addr=%0d wd=%h want 1/1/1/5/beef", m_en1, m_we1, d_gnt1, m_addr1, m_wdata1);
    else n_pass++;
    tick();
    ref_mem[5] = 16'hBEEF;
    d_we = 1'b0; d_wdata = '0;
    #3;
    n_checks++;
    if ({d_gnt1, m_we1, m_wdata1, d_rvalid1, d_rvalid2} !== {2'b10, 16'h0, 2'b00})
      $display("FAIL load_grant got gnt=%b we=%b wd=%h rv=%b%b want 1/0/0/00", d_gnt1, m_we1, m_wdata1, d_rvalid1, d_rvalid2);
    else n_pass++;
    tick();
    idle();
    #3;
    n_checks++;
    if ({d_rvalid1, d_rdata1, d_rvalid2} !== {1'b1, 16'hBEEF, 1'b0})
      $display("FAIL load_resp1 got %b/%h rv2=%b want 1/beef rv2=0", d_rvalid1, d_rdata1, d_rvalid2);
    else n_pass++;
    tick();
    #3;
    n_checks++;
    if ({d_rvalid2, d_rdata2, d_rvalid1} !== {1'b1, 16'hBEEF, 1'b0})
      $display("FAIL load_resp2 got %b/%h rv1=%b want 1/beef rv1=0", d_rvalid2, d_rdata2, d_rvalid1);
    else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    idle(); f_req = 1'b1; f_addr = 15'd10; tick();
    f_addr = 15'd11;
    #3;
    n_checks++;
    if ({f_rvalid1, f_rdata1} !== {1'b1, init_val(10)})
      $display("FAIL flush_pre1 got %b/%h want 1/%h", f_rvalid1, f_rdata1, init_val(10));
    else n_pass++;
    tick();
    f_addr = 15'd40; f_flush = 1'b1;
    #3;
    n_checks++;
    if ({f_gnt1, m_addr1, f_rvalid1, f_rvalid2} !== {1'b1, 15'd40, 2'b00})
      $display("FAIL flush_cycle got gnt=%b addr=%0d rv=%b%b want 1/40/00", f_gnt1, m_addr1, f_rvalid1, f_rvalid2);
    else n_pass++;
    tick();
    idle();
    #3;
    n_checks++;
    if ({f_rvalid1, f_rdata1, f_rvalid2} !== {1'b1, init_val(40), 1'b0})
      $display("FAIL flush_after1 got rv1=%b/%h rv2=%b want 1/%h rv2=0", f_rvalid1, f_rdata1, f_rvalid2, init_val(40));
    else n_pass++;
    tick();
    #3;
    n_checks++;
    if ({f_rvalid2, f_rdata2, f_rvalid1} !== {1'b1, init_val(40), 1'b0})
      $display("FAIL flush_after2 got rv2=%b/%h rv1=%b want 1/%h rv1=0", f_rvalid2, f_rdata2, f_rvalid1, init_val(40));
    else n_pass++;
    tick();
  endtask

  task automatic test_flush_data();
    idle(); d_req = 1'b1; d_addr = 15'd7; tick();
    idle(); f_flush = 1'b1;
    #3;
    n_checks++;
    if ({d_rvalid1, d_rdata1, f_rvalid1} !== {1'b1, init_val(7), 1'b0})
      $display("FAIL flush_data1 got d=%b/%h f=%b want 1/%h f=0", d_rvalid1, d_rdata1, f_rvalid1, init_val(7));
    else n_pass++;
    tick();
    f_flush = 1'b0;
    #3;
    n_checks++;
    if ({d_rvalid2, d_rdata2} !== {1'b1, init_val(7)})
      $display("FAIL flush_data2 got %b/%h want 1/%h", d_rvalid2, d_rdata2, init_val(7));
    else n_pass++;
    tick();
  endtask

  function automatic logic [33:0] expect_resp(input resp_t q[$], input int c, input logic flush);
    logic [33:0] r;
    r = '0;
    foreach (q[i]) begin
      if (q[i].due == c) begin
        if (q[i].src) r[16:0] = {1'b1, q[i].data};
        else if (!flush) r[33:17] = {1'b1, q[i].data};
      end
    end
    return r;
  endfunction

  task automatic test_random(input int n);
    resp_t q1[$], q2[$], t1[$], t2[$];
    resp_t r;
    int wcnt;
    bit f_hold, d_hold, e_fg, e_dg, e_we, e_starve;
    logic [14:0] e_addr;
    logic [15:0] e_wdata;
    logic [33:0] e_r1, e_r2;
    idle(); rst = 1'b1; tick(); rst = 1'b0;
    wcnt = 0; f_hold = 1'b0; d_hold = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (!f_hold) begin
        f_req  = ($urandom_range(0, 3) != 0);
        f_addr = 15'($urandom_range(0, 63));
      end
      if (!d_hold) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = ($urandom_range(0, 2) == 0);
        d_addr  = 15'($urandom_range(0, 63));
        d_wdata = 16'($urandom);
      end
      f_flush = ($urandom_range(0, 7) == 0);
      e_starve = (wcnt == MW);
      if (f_req && d_req) begin
        e_fg = e_starve; e_dg = !e_starve;
      end else begin
        e_fg = f_req; e_dg = d_req;
      end
      e_we    = e_dg && d_we;
      e_addr  = e_dg ? d_addr : (e_fg ? f_addr : 15'd0);
      e_wdata = e_we ? d_wdata : 16'd0;
      e_r1 = expect_resp(q1, c, f_flush);
      e_r2 = expect_resp(q2, c, f_flush);
      #3;
      n_checks++;
      if ({f_gnt1, d_gnt1, starve1, m_en1, m_we1} !== {e_fg, e_dg, e_starve, e_fg | e_dg, e_we})
        $display("FAIL rand_ctrl1 c=%0d got %b want %b", c, {f_gnt1, d_gnt1, starve1, m_en1, m_we1}, {e_fg, e_dg, e_starve, e_fg | e_dg, e_we});
      else n_pass++;
      n_checks++;
      if ({f_gnt2, d_gnt2, starve2, m_en2, m_we2} !== {e_fg, e_dg, e_starve, e_fg | e_dg, e_we})
        $display("FAIL rand_ctrl2 c=%0d got %b want %b", c, {f_gnt2, d_gnt2, starve2, m_en2, m_we2}, {e_fg, e_dg, e_starve, e_fg | e_dg, e_we});
      else n_pass++;
      n_checks++;
      if ({m_addr1, m_wdata1} !== {e_addr, e_wdata})
        $display("FAIL rand_mem c=%0d got addr=%0d wd=%h want addr=%0d wd=%h", c, m_addr1, m_wdata1, e_addr, e_wdata);
      else n_pass++;
      n_checks++;
      if ({f_rvalid1, f_rdata1, d_rvalid1, d_rdata1} !== e_r1)
        $display("FAIL rand_resp1 c=%0d got %h want %h", c, {f_rvalid1, f_rdata1, d_rvalid1, d_rdata1}, e_r1);
      else n_pass++;
      n_checks++;
      if ({f_rvalid2, f_rdata2, d_rvalid2, d_rdata2} !== e_r2)
        $display("FAIL rand_resp2 c=%0d got %h want %h", c, {f_rvalid2, f_rdata2, d_rvalid2, d_rdata2}, e_r2);
      else n_pass++;
      t1 = {}; t2 = {};
      foreach (q1[i]) if (q1[i].due > c && !(f_flush && !q1[i].src)) t1.push_back(q1[i]);
      foreach (q2[i]) if (q2[i].due > c && !(f_flush && !q2[i].src)) t2.push_back(q2[i]);
      q1 = t1; q2 = t2;
      if (e_fg || (e_dg && !d_we)) begin
        r.src  = e_dg;
        r.data = ref_mem[e_addr[5:0]];
        r.due  = c + 1; q1.push_back(r);
        r.due  = c + 2; q2.push_back(r);
      end
      if (e_we) ref_mem[d_addr[5:0]] = d_wdata;
      wcnt   = (f_req && !e_fg) ? ((wcnt < MW) ? wcnt + 1 : MW) : 0;
      f_hold = f_req && !e_fg;
      d_hold = d_req && !e_dg;
      tick();
    end
    idle(); tick(); tick();
  endtask

  initial begin
    idle();
    rst = 1'b1; mem_load = 1'b1;
    for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
    tick(); tick();
    mem_load = 1'b0; rst = 1'b0;
    tick(); tick();
    test_reset();
    test_fetch_only();
    test_contention();
    test_store_load();
    test_flush();
    test_flush_data();
    test_random(600);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
